// File: rtl/hamming_secded_enc_stream.sv
// ============================================================================
// Module   : hamming_secded_enc_stream
// Brief    : Streaming SECDED Hamming encoder with 2-entry output buffer,
//            per-word error-injection mask and emitted-word counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hamming_secded_enc_stream_pkg;
  // Smallest m with 2**m >= m + k + 1; must match the decoder's derivation.
  function automatic int calculate_m(input int k);
    int m;
    m = 1;
    while ((2 ** m) < (m + k + 1)) m++;
    return m;
  endfunction
endpackage

module hamming_secded_enc_stream
  import hamming_secded_enc_stream_pkg::*;
#(
  parameter  int K     = 8,
  parameter  int CNT_W = 16,
  localparam int M     = calculate_m(K),
  localparam int N     = M + K
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [K-1:0]     in_data_i,
  input  logic [N:0]       inj_mask_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [N:0]       out_data_o,
  output logic             out_inj_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [N:0]       w_cw;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_count_next;

  logic [N:0]       r_data [2];
  logic [1:0]       r_inj;
  logic             r_head;
  logic             r_tail;
  logic [1:0]       r_count;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_cnt;

  // Data bits fill non-power-of-two positions in ascending order, then each
  // p(2**j) covers the data positions whose index has bit j set.
  always_comb begin
    int di;
    w_cw = '0;
    di   = 0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        w_cw[p] = in_data_i[di];
        di++;
      end
    end
    for (int j = 0; j < M; j++) begin
      for (int p = 1; p <= N; p++) begin
        if (((p & (p - 1)) != 0) && p[j]) w_cw[2 ** j] = w_cw[2 ** j] ^ w_cw[p];
      end
    end
    w_cw[0] = ^w_cw[N:1];
  end

  assign w_push       = in_valid_i && r_in_ready;
  assign w_pop        = (r_count != 2'd0) && out_ready_i;
  assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data[0]  <= '0;
      r_data[1]  <= '0;
      r_inj      <= '0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_push) begin
        r_data[r_tail] <= w_cw ^ inj_mask_i;
        r_inj[r_tail]  <= |inj_mask_i;
        r_tail         <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
        r_cnt  <= r_cnt + 1'b1;
      end
      r_count    <= w_count_next;
      r_in_ready <= (w_count_next != 2'd2);
    end
  end

  // Gating with rst_i keeps a mid-operation reset cycle from advertising a transfer.
  assign in_ready_o  = r_in_ready && !rst_i;
  assign out_valid_o = (r_count != 2'd0) && !rst_i;
  assign out_data_o  = r_data[r_head];
  assign out_inj_o   = r_inj[r_head];
  assign cnt_o       = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hamming_secded_enc_stream.sv
// ============================================================================
// Module   : tb_hamming_secded_enc_stream
// Brief    : Directed-vector bench for the streaming SECDED encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hamming_secded_enc_stream;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [7:0]  in_data_i;
  logic [12:0] inj_mask_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [12:0] out_data_o;
  logic        out_inj_o;
  logic [15:0] cnt_o;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [7:0]  data;
    logic [12:0] mask;
    logic [12:0] cw;
    logic        inj;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  hamming_secded_enc_stream #(.K(8), .CNT_W(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .inj_mask_i  (inj_mask_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_inj_o   (out_inj_o),
    .cnt_o       (cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{8'h05, 13'h0000, 13'h005A, 1'b0};
    vecs[1]  = '{8'hFF, 13'h0000, 13'h1EEE, 1'b0};
    vecs[2]  = '{8'h00, 13'h0000, 13'h0000, 1'b0};
    vecs[3]  = '{8'h05, 13'h0040, 13'h001A, 1'b1};
    vecs[4]  = '{8'h05, 13'h0C00, 13'h0C5A, 1'b1};
    vecs[5]  = '{8'h80, 13'h0000, 13'h1111, 1'b0};
    vecs[6]  = '{8'hAA, 13'h0000, 13'h14B1, 1'b0};
    vecs[7]  = '{8'h55, 13'h0000, 13'h0A5F, 1'b0};
    vecs[8]  = '{8'h01, 13'h0000, 13'h000F, 1'b0};
    vecs[9]  = '{8'h02, 13'h0000, 13'h0033, 1'b0};
    vecs[10] = '{8'h03, 13'h0000, 13'h003C, 1'b0};

    rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
    in_data_i = '0; inj_mask_i = '0;
    tick();
    check("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_out_data", {19'd0, out_data_o}, 32'd0);
    check("rst_out_inj", {31'd0, out_inj_o}, 32'd0);
    check("rst_cnt", {16'd0, cnt_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    check("post_rst_in_ready", {31'd0, in_ready_o}, 32'd1);

    // Streaming table: each word appears one cycle after acceptance.
    out_ready_i = 1'b1;
    for (int i = 0; i < NV; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = vecs[i].data;
      inj_mask_i = vecs[i].mask;
      tick();
      check("vec_valid", {31'd0, out_valid_o}, 32'd1);
      check("vec_data", {19'd0, out_data_o}, {19'd0, vecs[i].cw});
      check("vec_inj", {31'd0, out_inj_o}, {31'd0, vecs[i].inj});
      check("vec_in_ready", {31'd0, in_ready_o}, 32'd1);
      check("vec_cnt", {16'd0, cnt_o}, i);
    end
    in_valid_i = 1'b0; inj_mask_i = '0;
    tick();
    check("drain_valid", {31'd0, out_valid_o}, 32'd0);
    check("drain_cnt", {16'd0, cnt_o}, NV);
    tick();
    check("idle_ready_cnt", {16'd0, cnt_o}, NV);

    // Backpressure: third word held until space frees.
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_data_i = 8'h01;
    tick();
    check("bp_ready1", {31'd0, in_ready_o}, 32'd1);
    in_data_i = 8'h02;
    tick();
    check("bp_ready2", {31'd0, in_ready_o}, 32'd0);
    in_data_i = 8'h03;
    tick();
    check("bp_hold_ready", {31'd0, in_ready_o}, 32'd0);
    check("bp_hold_data", {19'd0, out_data_o}, 32'h000F);
    out_ready_i = 1'b1;
    tick();
    check("bp_ready_back", {31'd0, in_ready_o}, 32'd1);
    check("bp_second", {19'd0, out_data_o}, 32'h0033);
    tick();
    in_valid_i = 1'b0;
    check("bp_third", {19'd0, out_data_o}, 32'h003C);
    check("bp_third_valid", {31'd0, out_valid_o}, 32'd1);
    tick();
    check("bp_empty", {31'd0, out_valid_o}, 32'd0);
    check("bp_cnt", {16'd0, cnt_o}, NV + 3);

    // Reset with two words buffered discards them.
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_data_i = 8'h11;
    tick();
    in_data_i = 8'h22;
    tick();
    in_valid_i = 1'b0;
    check("pre_rst_valid", {31'd0, out_valid_o}, 32'd1);
    rst_i = 1'b1; out_ready_i = 1'b1;
    #1;
    check("in_rst_valid", {31'd0, out_valid_o}, 32'd0);
    tick();
    check("mid_rst_valid", {31'd0, out_valid_o}, 32'd0);
    check("mid_rst_cnt", {16'd0, cnt_o}, 32'd0);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_no_word", {31'd0, out_valid_o}, 32'd0);
    end
    check("mid_rst_ready", {31'd0, in_ready_o}, 32'd1);

    // Counter wrap: 65536 streaming edges give 65535 pops, then one more.
    in_valid_i = 1'b1; in_data_i = 8'h00; inj_mask_i = '0;
    for (int i = 0; i < 65536; i++) tick();
    check("cnt_max", {16'd0, cnt_o}, 32'h0000FFFF);
    in_valid_i = 1'b0;
    tick();
    check("cnt_wrap", {16'd0, cnt_o}, 32'd0);
    check("cnt_wrap_empty", {31'd0, out_valid_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hamming_secded_enc_stream.md
Name: hamming_secded_enc_stream

Overview:
- Streaming SECDED Hamming encoder; the transmit-side counterpart of the team's decoder.
- Accepts K-bit information words over a valid/ready handshake and produces (N+1)-bit extended codewords. The codeword layout is bit-exact with the decoder's d_i input.
- Buffers up to two codewords so throughput is one word per clock under downstream backpressure.
- Includes a per-word error-injection mask and an emitted-word counter. These exist to drive the decoder in system-level checks.

Parameters:
- K, 8, information bits per word.
- M, calculate_m(K): smallest m with 2**m >= m+K+1. Same function as the decoder. Derived; not overridden. M=4 for K=8.
- N, M+K, Hamming codeword length excluding overall parity. N=12 for K=8.
- CNT_W, 16, width of emitted-word counter.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- in_valid_i  in  1  in_data_i/inj_mask_i valid.
- in_ready_o  out  1  block can accept a word this cycle.
- in_data_i  in  K  information word.
- inj_mask_i  in  N+1  XOR mask applied to the codeword of this beat.
- out_valid_o  out  1  out_data_o valid.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  N+1  extended codeword, index [N:0].
- out_inj_o  out  1  high when the presented word's mask was nonzero.
- cnt_o  out  CNT_W  count of completed output handshakes.

Behaviour:
- Handshakes:
  - Input transfer occurs when in_valid_i && in_ready_o.
  - Output transfer occurs when out_valid_o && out_ready_i.
  - out_data_o and out_inj_o are held stable while out_valid_o && !out_ready_i.
- Codeword layout:
  - Bit 0 is overall parity.
  - Bits 1..N are Hamming positions; positions 2**j are parity bits p(2**j).
  - Data bits fill the remaining positions in ascending order: in_data_i[0] goes to position 3, [1] to 5, [2] to 6, [3] to 7, [4] to 9, and so on up to [7] at position 12.
  - p(2**j) is the XOR of all data positions whose index has bit j set.
  - Bit 0 is the XOR of bits 1..N, giving even overall parity.
  - The stored word is codeword ^ inj_mask_i.
- Encoding is combinational on the input beat and is written directly into the buffer. No extra pipeline stage.
- Buffer:
  - 2-entry FIFO: head/tail pointer regs plus a 2-bit count.
  - in_ready_o = (count != 2), driven from a register (no combinational path from out_ready_i).
  - out_valid_o = (count != 0).
  - Latency: a word accepted in cycle t is presented at out_data_o in cycle t+1.
  - count=0 with push: count becomes 1.
  - count=1 with push and pop in the same cycle: count stays 1, and the new word is at head in the next cycle.
  - count=2: no push is possible (in_ready_o=0). A pop makes count 1, and in_ready_o=1 in the next cycle.
  - count=0 with out_ready_i high: no pop and no counter change.
- Ordering: strict FIFO.
- Injection: out_inj_o = |inj_mask_i of the stored entry. The mask is stored per entry.
- Counter: cnt_o increments on each output transfer and wraps from 2**CNT_W-1 to 0.
- Reset:
  - Reset values: in_ready_o=0 during reset and 1 the cycle after; out_valid_o=0; out_data_o=0; out_inj_o=0; cnt_o=0; pointers=0; count=0.
  - Reset mid-operation discards buffered words. No output transfer is signalled in the reset cycle.

Test Plan:
- Reset, then in_data_i=8'h05, mask=0, out_ready_i=1 -> next cycle out_valid_o=1, out_data_o=13'h005A, out_inj_o=0, cnt_o=1 after transfer.
- in_data_i=8'hFF, then 8'h00 back-to-back with out_ready_i=1 -> 13'h1EEE then 13'h0000 on consecutive cycles; in_ready_o stays 1.
- 8'h05 with mask=13'h0040 (bit 6) -> out_data_o=13'h001A, out_inj_o=1. Fed to the decoder, this gives sb_err_o=1 and q_o=8'h05. Mask 13'h0C00 gives out_data_o=13'h0C5A and decoder db_err_o=1.
- Backpressure: out_ready_i=0, push 8'h01, 8'h02, 8'h03 -> in_ready_o drops after the 2nd accept and the 3rd is held. Release out_ready_i -> codewords for 01 then 02 exit in order, then 03 is accepted.
- Assert rst_i with 2 words buffered -> next cycle out_valid_o=0, cnt_o=0. The buffered words never appear.
- Force cnt_o to 16'hFFFF via 65535 transfers or preload in sim, then one transfer -> cnt_o=0.
